// File: rtl/universal_register.sv
// Parametrised working register: load, multi-cycle shift/rotate by a programmable
// amount, increment/decrement, with a start/busy/done handshake.
module universal_register #(
  parameter int unsigned       WIDTH       = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int unsigned      AMT_W       = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ModeLoad = 3'b000,
    ModeShl  = 3'b001,
    ModeShr  = 3'b010,
    ModeAsr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101,
    ModeInc  = 3'b110,
    ModeDec  = 3'b111
  } mode_e;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] step_q;
  logic             step_c;

  assign q_bar = ~q;

  // One 1-bit step of the latched shift mode; carry takes the bit leaving q.
  always_comb begin
    step_q = q;
    step_c = carry;
    case (mode_q)
      ModeShl: begin
        step_q = {q[WIDTH-2:0], sin};
        step_c = q[WIDTH-1];
      end
      ModeShr: begin
        step_q = {sin, q[WIDTH-1:1]};
        step_c = q[0];
      end
      ModeAsr: begin
        step_q = {q[WIDTH-1], q[WIDTH-1:1]};
        step_c = q[0];
      end
      ModeRol: begin
        step_q = {q[WIDTH-2:0], q[WIDTH-1]};
        step_c = q[WIDTH-1];
      end
      ModeRor: begin
        step_q = {q[0], q[WIDTH-1:1]};
        step_c = q[0];
      end
      default: begin
        step_q = q;
        step_c = carry;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VALUE;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      state_q <= StIdle;
      mode_q  <= ModeLoad;
      cnt_q   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            unique case (mode_e'(mode))
              ModeLoad: begin
                q     <= d;
                carry <= 1'b0;
                done  <= 1'b1;
              end
              ModeInc: begin
                {carry, q} <= {1'b0, q} + (WIDTH + 1)'(1);
                done       <= 1'b1;
              end
              // Borrow lands in the extra top bit of the widened subtraction.
              ModeDec: begin
                {carry, q} <= {1'b0, q} - (WIDTH + 1)'(1);
                done       <= 1'b1;
              end
              default: begin
                if (amt == '0) begin
                  done <= 1'b1;
                end else begin
                  mode_q  <= mode_e'(mode);
                  cnt_q   <= amt;
                  busy    <= 1'b1;
                  state_q <= StShift;
                end
              end
            endcase
          end
        end
        StShift: begin
          q     <= step_q;
          carry <= step_c;
          cnt_q <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_register.sv
// Scoreboard bench for universal_register (WIDTH=4): stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_universal_register;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [WIDTH-1:0] d = '0;
  logic [AMT_W-1:0] amt = '0;
  logic             sin = 1'b0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             carry;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  q;
    logic        c;
    int unsigned b;
  } exp_t;

  exp_t sb[$];

  universal_register #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(4'b0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .mode (mode),
    .d    (d),
    .amt  (amt),
    .sin  (sin),
    .q    (q),
    .q_bar(q_bar),
    .carry(carry),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles and checks each completed operation.
  int unsigned busy_run = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: q=%b carry=%b", q, carry);
          end else begin
            e = sb.pop_front();
            if (q !== e.q || q_bar !== ~e.q || carry !== e.c || busy_run != e.b || busy !== 1'b0)
            begin
              errors++;
              $display("FAIL op_result: got q=%b q_bar=%b c=%b busy_cycles=%0d busy=%b, expected q=%b q_bar=%b c=%b busy_cycles=%0d busy=0",
                       q, q_bar, carry, busy_run, busy, e.q, ~e.q, e.c, e.b);
            end
          end
          busy_run = 0;
        end
      end
    end
  end

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic do_op(input logic [2:0] m, input logic [3:0] dv, input logic [2:0] a,
                       input logic s, input logic [3:0] eq, input logic ec, input int unsigned eb,
                       input bit inject, input bit probe, input logic [3:0] pq, input logic pc);
    bit got = 0;
    sb.push_back('{q: eq, c: ec, b: eb});
    @(negedge clk);
    start = 1'b1; mode = m; d = dv; amt = a; sin = s;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (inject && busy) begin
        start = 1'b1; mode = 3'b000; d = 4'b0001;
      end else begin
        start = 1'b0;
      end
      if (probe && i == 0) check("first_cycle_q_unchanged", {3'b0, busy, q}, {3'b0, 1'b1, dv});
      if (probe && i == 1) check("first_step", {3'b0, carry, q}, {3'b0, pc, pq});
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 40 cycles");
    end
  endtask

  task automatic load(input logic [3:0] v);
    do_op(3'b000, v, 3'd0, 1'b0, v, 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {q_bar, q}, 8'b1111_0000);
    check("reset_flags", {5'b0, carry, busy, done}, 8'b0);

    // LOAD, then ROL by 2 with intermediate step checked (probe d is current q)
    load(4'b1011);
    do_op(3'b100, 4'b1011, 3'd2, 1'b0, 4'b1110, 1'b0, 2, 1'b0, 1'b1, 4'b0111, 1'b1);

    load(4'b1000);
    do_op(3'b011, 4'b0000, 3'd3, 1'b0, 4'b1111, 1'b0, 3, 1'b0, 1'b0, 4'b0, 1'b0);
    load(4'b1001);
    do_op(3'b010, 4'b0000, 3'd5, 1'b0, 4'b0000, 1'b0, 5, 1'b0, 1'b0, 4'b0, 1'b0);
    load(4'b1011);
    do_op(3'b001, 4'b0000, 3'd0, 1'b0, 4'b1011, 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    do_op(3'b001, 4'b0000, 3'd2, 1'b1, 4'b1111, 1'b0, 2, 1'b0, 1'b0, 4'b0, 1'b0);
    load(4'b1011);
    do_op(3'b101, 4'b0000, 3'd5, 1'b0, 4'b1101, 1'b1, 5, 1'b0, 1'b0, 4'b0, 1'b0);

    load(4'b1111);
    do_op(3'b110, 4'b0000, 3'd0, 1'b0, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    do_op(3'b111, 4'b0000, 3'd0, 1'b0, 4'b1111, 1'b1, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    load(4'b0101);
    do_op(3'b110, 4'b0000, 3'd0, 1'b0, 4'b0110, 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    do_op(3'b111, 4'b0000, 3'd0, 1'b0, 4'b0101, 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);

    // ROR by 3 from 0101 with a LOAD start held throughout busy
    do_op(3'b101, 4'b0000, 3'd3, 1'b0, 4'b1010, 1'b1, 3, 1'b1, 1'b0, 4'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("after_ignored_load", {3'b0, carry, q}, {3'b0, 1'b1, 4'b1010});

    // Reset mid-shift: no done pulse may follow
    load(4'b1011);
    @(negedge clk);
    start = 1'b1; mode = 3'b100; amt = 3'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_before_abort", {7'b0, busy}, 8'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {q_bar, q}, 8'b1111_0000);
    check("abort_flags", {5'b0, carry, busy, done}, 8'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {6'b0, busy, done}, 8'b0);
    end

    check("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
